// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing (pixel_clk, async active-low rst -> hpos/vpos/hsync/vsync/de/fsync, frame_cnt when VTG_FRAME_COUNT_EN is defined)
module video_timing_gen #(
  parameter int HRES      = 1280,
  parameter int HFP       = 110,
  parameter int HSYNC     = 40,
  parameter int HBP       = 220,
  parameter int VRES      = 720,
  parameter int VFP       = 5,
  parameter int VSYNC     = 5,
  parameter int VBP       = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
`ifdef VTG_FRAME_COUNT_EN
  output logic        [15:0] frame_cnt,
`endif
  output logic               fsync
);
  localparam int H_TOTAL = HRES + HFP + HSYNC + HBP;
  localparam int V_TOTAL = VRES + VFP + VSYNC + VBP;
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_chk
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 2047");
  end
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(HRES);
  localparam logic [10:0] V_ACT  = 11'(VRES);
  localparam logic [10:0] HS_BEG = 11'(HRES + HFP);
  localparam logic [10:0] HS_END = 11'(HRES + HFP + HSYNC);
  localparam logic [10:0] VS_BEG = 11'(VRES + VFP);
  localparam logic [10:0] VS_END = 11'(VRES + VFP + VSYNC);
  logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        h_wrap, hs_on, vs_on;
  always_comb begin
    h_wrap = h_cnt == H_LAST;
    h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_nxt  = !h_wrap ? v_cnt : v_cnt == V_LAST ? 11'd0 : v_cnt + 11'd1;
    hs_on  = h_nxt >= HS_BEG && h_nxt < HS_END;
    vs_on  = v_nxt >= VS_BEG && v_nxt < VS_END;
  end
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
      hsync <= !HSYNC_POL;
      vsync <= !VSYNC_POL;
      de    <= 1'b0;
      fsync <= 1'b0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hsync <= hs_on ? HSYNC_POL : !HSYNC_POL;
      vsync <= vs_on ? VSYNC_POL : !VSYNC_POL;
      de    <= h_nxt < H_ACT && v_nxt < V_ACT;
      fsync <= h_nxt == 11'd0 && v_nxt == V_ACT;
    end
  end
  assign hpos = {1'b0, h_cnt};
  assign vpos = {1'b0, v_cnt};
`ifdef VTG_FRAME_COUNT_EN
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) frame_cnt <= 16'd0;
    else      frame_cnt <= frame_cnt + 16'(fsync);
  end
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized reset/run bench against a linear pixel-index raster model
module tb_video_timing_gen;
  localparam int HRES = 16, HFP = 3, HSYNC = 4, HBP = 5;
  localparam int VRES = 10, VFP = 2, VSYNC = 3, VBP = 4;
  localparam int HT = HRES + HFP + HSYNC + HBP;
  localparam int VT = VRES + VFP + VSYNC + VBP;
  localparam int P  = HT * VT;
  logic pixel_clk = 1'b0;
  logic rst = 1'b0;
  logic signed [11:0] hpos, vpos;
  logic hsync, vsync, de, fsync;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif
  always #5 pixel_clk = ~pixel_clk;
  video_timing_gen #(
    .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .hpos(hpos),
    .vpos(vpos),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
`ifdef VTG_FRAME_COUNT_EN
    .frame_cnt(frame_cnt),
`endif
    .fsync(fsync)
  );
  int n_chk = 0, n_fail = 0;
  int t = 0, cyc = 0, last_fs = -1, n_fs = 0;
  bit in_rst = 1'b1;
  logic [15:0] fc = 16'd0;
  task automatic chk(string tag, logic [31:0] obs, int exp);
    n_chk++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask
  task automatic check_all();
    int h, v;
    h = in_rst ? HT - 1 : t % HT;
    v = in_rst ? VT - 1 : t / HT;
    chk("hpos", 32'(hpos), h);
    chk("vpos", 32'(vpos), v);
    chk("de", 32'(de), int'(!in_rst && h < HRES && v < VRES));
    chk("hsync", 32'(hsync), int'(!in_rst && h >= HRES + HFP && h < HRES + HFP + HSYNC));
    chk("vsync", 32'(vsync), int'(!in_rst && v >= VRES + VFP && v < VRES + VFP + VSYNC));
    chk("fsync", 32'(fsync), int'(!in_rst && h == 0 && v == VRES));
`ifdef VTG_FRAME_COUNT_EN
    chk("frame_cnt", 32'(frame_cnt), int'(fc));
`endif
  endtask
  task automatic step();
    @(posedge pixel_clk);
    if (rst) begin
      if (!in_rst && t == VRES * HT) fc++;
      t = in_rst ? 0 : (t + 1) % P;
      in_rst = 1'b0;
    end
    cyc++;
    #2;
    check_all();
    if (fsync === 1'b1) begin
      n_fs++;
      if (last_fs >= 0) chk("frame_period", cyc - last_fs, P);
      last_fs = cyc;
    end
  endtask
  task automatic async_reset(int hold);
    rst = 1'b0;
    in_rst = 1'b1;
    fc = 16'd0;
    last_fs = -1;
    #1;
    check_all();
    repeat (hold) step();
    rst = 1'b1;
  endtask
  initial begin
    repeat (10) step();
    rst = 1'b1;
    step();
    n_fs = 0;
    repeat (3 * P) step();
    chk("fsync_count_3_frames", n_fs, 3);
    while (t != 5 * HT + 7) step();
    async_reset(3);
    step();
`ifdef VTG_FRAME_COUNT_EN
    repeat (P / 2) step();
    force dut.frame_cnt = 16'hffff;
    #1;
    release dut.frame_cnt;
    fc = 16'hffff;
    repeat (P) step();
`endif
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(20, 600)) step();
      async_reset(int'($urandom_range(0, 4)));
      step();
    end
    repeat (P + 5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source for the Pong display pipeline; runs on the pixel clock and produces the hpos/vpos/fsync bus that every sprite block (paddles, ball) consumes.
- Also produces hsync/vsync/de for the HDMI/TMDS encoder.
- Default timing is CEA-861 1280x720p60 (74.25 MHz pixel clock).
- Coordinates are raw counter values, so blanking positions always fall outside the 0..HRES-1 / 0..VRES-1 active window.

Parameters:
- HRES, 1280, active pixels per line
- HFP, 110, horizontal front porch (clocks)
- HSYNC, 40, horizontal sync width (clocks)
- HBP, 220, horizontal back porch (clocks)
- VRES, 720, active lines per frame
- VFP, 5, vertical front porch (lines)
- VSYNC, 5, vertical sync width (lines)
- VBP, 20, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- hpos  out  12 signed  horizontal counter, 0..H_TOTAL-1
- vpos  out  12 signed  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  data enable, high inside the active window
- fsync  out  1  one-clock pulse per frame at start of vertical blanking
- frame_cnt  out  16  frames completed (only when VTG_FRAME_COUNT_EN is defined)

Behaviour:
- Derived constants:
  - H_TOTAL = HRES+HFP+HSYNC+HBP (default 1650)
  - V_TOTAL = VRES+VFP+VSYNC+VBP (default 750)
  - Both must be ≤2047; elaboration fails otherwise.
- Counters h_cnt and v_cnt:
  - h_cnt increments every pixel_clk and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on an h_cnt wrap and wraps V_TOTAL-1 -> 0 when both counters wrap together.
- All outputs are registered and mutually aligned: on any cycle, hsync/vsync/de/fsync describe the position currently shown on hpos/vpos.
  - hpos = h_cnt, vpos = v_cnt, zero-extended into 12-bit signed; never negative.
  - de = (h_cnt < HRES) && (v_cnt < VRES).
  - hsync asserted when HRES+HFP ≤ h_cnt ≤ HRES+HFP+HSYNC-1 (default 1390..1429).
  - vsync asserted for whole lines VRES+VFP ≤ v_cnt ≤ VRES+VFP+VSYNC-1 (default 725..729). vsync transitions coincide with h_cnt = 0.
  - fsync = 1 exactly when h_cnt = 0 and v_cnt = VRES (default line 720). Exactly one pulse per frame, a full blanking interval before the next active pixel, so sprite position updates never tear.
- Reset (rst low, asynchronous):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so hpos = 1649 and vpos = 749.
  - de = 0, fsync = 0, hsync and vsync at their deasserted levels, frame_cnt = 0.
- Reset release: the first pixel_clk rising edge with rst high moves the counters to (0,0) with de = 1. Release is assumed synchronised upstream.
- Reset asserted mid-frame: outputs go to the reset values immediately, with no partial pulses after assertion. The frame restarts cleanly from (0,0).
- No enable input; the block free-runs. Period = H_TOTAL*V_TOTAL clocks (default 1,237,500).

Optional Feature:
- Macro VTG_FRAME_COUNT_EN.
- Defined:
  - frame_cnt port exists.
  - Increments by 1, wrapping at 65535 -> 0, on the same clock that fsync is asserted.
  - The new value is visible the cycle after the fsync pulse.
  - Reset value 0.
- Not defined: frame_cnt port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset release:
  - Hold rst=0 for 10 clks -> hpos=1649, vpos=749, de=0, hsync=0, vsync=0, fsync=0.
  - Release -> first edge gives hpos=0, vpos=0, de=1.
- Line timing:
  - de high for hpos 0..1279, low for 1280..1649.
  - hsync high for exactly hpos 1390..1429 (40 clks).
  - hpos wraps 1649 -> 0 while vpos increments.
- Frame timing:
  - vsync high from (0,725) through (1649,729) = 5*1650 clks.
  - de low on lines 720..749.
  - Frame period measured between successive fsync pulses = 1,237,500 clks.
- fsync uniqueness: over 3 frames, exactly 3 single-cycle pulses, each coincident with hpos=0, vpos=720.
- Mid-frame reset: assert rst=0 at hpos=700, vpos=300 -> outputs take reset values asynchronously, before the next edge; after release, counting restarts at (0,0).
- Build with VTG_FRAME_COUNT_EN:
  - frame_cnt reads 0,1,2 after successive fsync pulses.
  - Preload via force to 65535 -> wraps to 0 after the next fsync.
